// File: rtl/paint_ctrl_gen2.sv
// Frame-tick command sequencer for the paint canvas: cursor, palette, colour commit, VRAM write.
// Optional macro PAINT_BRUSH2X2_EN turns the single-pixel write into a clipped 2x2 brush.
module paint_ctrl_gen2 #(
  parameter int unsigned X_W      = 5,
  parameter int unsigned Y_W      = 5,
  parameter int unsigned PAL_W    = 3,
  parameter int unsigned PAL_SIZE = 8,
  parameter bit          WRAP     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_init,
  input  logic               key_c,
  input  logic               key_enter,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               wr_ack,
  output logic [X_W-1:0]     cursor_x,
  output logic [Y_W-1:0]     cursor_y,
  output logic [PAL_W-1:0]   pal_cursor,
  output logic [PAL_W-1:0]   color_idx,
  output logic               pal_mode,
  output logic               wr_req,
  output logic [X_W+Y_W-1:0] wr_addr,
  output logic [PAL_W-1:0]   wr_data,
  output logic               draw_cursor,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StMove,
    StPalMove,
    StChangeColor,
    StPaintReq,
    StDrawCursor,
    StDone
  } state_e;

  localparam logic [X_W-1:0]   XMax    = '1;
  localparam logic [Y_W-1:0]   YMax    = '1;
  localparam logic [X_W-1:0]   XOne    = 1;
  localparam logic [Y_W-1:0]   YOne    = 1;
  localparam logic [PAL_W-1:0] PalOne  = 1;
  localparam logic [PAL_W-1:0] PalLast = PAL_W'(PAL_SIZE - 1);

  state_e           state_q;
  // {c, enter, up, down, left, right}
  logic [5:0]       key_q;
  logic [X_W-1:0]   cursor_x_q;
  logic [Y_W-1:0]   cursor_y_q;
  logic [PAL_W-1:0] pal_cursor_q;
  logic [PAL_W-1:0] color_idx_q;
  logic             pal_mode_q;
  logic             wr_req_q;

  logic             any_dir;
  logic [X_W-1:0]   x_dec, x_inc;
  logic [Y_W-1:0]   y_dec, y_inc;
  logic [PAL_W-1:0] pal_dec, pal_inc;

  always_comb begin
    any_dir = |key_q[3:0];
    x_dec   = (WRAP || cursor_x_q != '0)  ? cursor_x_q - XOne : cursor_x_q;
    x_inc   = (WRAP || cursor_x_q != XMax) ? cursor_x_q + XOne : cursor_x_q;
    y_dec   = (WRAP || cursor_y_q != '0)  ? cursor_y_q - YOne : cursor_y_q;
    y_inc   = (WRAP || cursor_y_q != YMax) ? cursor_y_q + YOne : cursor_y_q;
    pal_dec = (pal_cursor_q == '0)      ? PalLast : pal_cursor_q - PalOne;
    pal_inc = (pal_cursor_q == PalLast) ? '0      : pal_cursor_q + PalOne;
  end

`ifdef PAINT_BRUSH2X2_EN
  // Brush pixel index: bit 0 = x offset, bit 1 = y offset.
  logic [1:0] sub_q;
  logic [1:0] next_sub;
  logic       has_next;

  always_comb begin
    has_next = 1'b0;
    next_sub = sub_q;
    for (int i = 3; i >= 1; i--) begin
      logic [1:0] cand;
      cand = 2'(i);
      if (cand > sub_q && !(cand[0] && cursor_x_q == XMax) && !(cand[1] && cursor_y_q == YMax)) begin
        has_next = 1'b1;
        next_sub = cand;
      end
    end
  end

  assign wr_addr = {cursor_y_q + Y_W'(sub_q[1]), cursor_x_q + X_W'(sub_q[0])};
`else
  assign wr_addr = {cursor_y_q, cursor_x_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      key_q        <= '0;
      cursor_x_q   <= '0;
      cursor_y_q   <= '0;
      pal_cursor_q <= '0;
      color_idx_q  <= '0;
      pal_mode_q   <= 1'b0;
      wr_req_q     <= 1'b0;
`ifdef PAINT_BRUSH2X2_EN
      sub_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_init) begin
            key_q   <= {key_c, key_enter, key_up, key_down, key_left, key_right};
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (key_q[5]) begin
            pal_mode_q <= ~pal_mode_q;
            state_q    <= StDrawCursor;
          end else if (key_q[4]) begin
            if (pal_mode_q) begin
              state_q <= StChangeColor;
            end else begin
              wr_req_q <= 1'b1;
`ifdef PAINT_BRUSH2X2_EN
              sub_q    <= '0;
`endif
              state_q  <= StPaintReq;
            end
          end else if (any_dir) begin
            state_q <= pal_mode_q ? StPalMove : StMove;
          end else begin
            state_q <= StDrawCursor;
          end
        end
        StMove: begin
          if (key_q[3])      cursor_y_q <= y_dec;
          else if (key_q[2]) cursor_y_q <= y_inc;
          else if (key_q[1]) cursor_x_q <= x_dec;
          else if (key_q[0]) cursor_x_q <= x_inc;
          state_q <= StDrawCursor;
        end
        StPalMove: begin
          // up/down take priority but leave the palette cursor alone
          if (!key_q[3] && !key_q[2]) begin
            if (key_q[1])      pal_cursor_q <= pal_dec;
            else if (key_q[0]) pal_cursor_q <= pal_inc;
          end
          state_q <= StDrawCursor;
        end
        StChangeColor: begin
          color_idx_q <= pal_cursor_q;
          pal_mode_q  <= 1'b0;
          state_q     <= StDrawCursor;
        end
        StPaintReq: begin
`ifdef PAINT_BRUSH2X2_EN
          // Request drops for one cycle between brush pixels so each write is its own handshake.
          if (wr_req_q) begin
            if (wr_ack) begin
              wr_req_q <= 1'b0;
              if (has_next) begin
                sub_q <= next_sub;
              end else begin
                sub_q   <= '0;
                state_q <= StDrawCursor;
              end
            end
          end else begin
            wr_req_q <= 1'b1;
          end
`else
          if (wr_ack) begin
            wr_req_q <= 1'b0;
            state_q  <= StDrawCursor;
          end
`endif
        end
        StDrawCursor: state_q <= StDone;
        StDone:       state_q <= StIdle;
        default:      state_q <= StIdle;
      endcase
    end
  end

  assign cursor_x    = cursor_x_q;
  assign cursor_y    = cursor_y_q;
  assign pal_cursor  = pal_cursor_q;
  assign color_idx   = color_idx_q;
  assign pal_mode    = pal_mode_q;
  assign wr_req      = wr_req_q;
  assign wr_data     = color_idx_q;
  assign draw_cursor = (state_q == StDrawCursor);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_paint_ctrl_gen2.sv
// Directed bench for paint_ctrl_gen2: wrapping DUT plus a clamping (WRAP=0) twin on shared inputs.
module tb_paint_ctrl_gen2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_init = 1'b0;
  logic       key_c = 1'b0, key_enter = 1'b0, key_up = 1'b0;
  logic       key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       wr_ack = 1'b0;

  logic [4:0] cursor_x, cursor_y, c_cursor_x, c_cursor_y;
  logic [2:0] pal_cursor, color_idx, wr_data, c_pal_cursor, c_color_idx, c_wr_data;
  logic       pal_mode, wr_req, draw_cursor, busy, done;
  logic       c_pal_mode, c_wr_req, c_draw_cursor, c_busy, c_done;
  logic [9:0] wr_addr, c_wr_addr;

  int total = 0;
  int bad   = 0;

  // Results of the last command
  int lat, n_wr, req_cyc;
  int wr_log[4];
  int data_log[4];

  always #5 clk = ~clk;

  paint_ctrl_gen2 #(.X_W(5), .Y_W(5), .PAL_W(3), .PAL_SIZE(8), .WRAP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_init(in_init), .key_c(key_c), .key_enter(key_enter),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .wr_ack(wr_ack), .cursor_x(cursor_x), .cursor_y(cursor_y), .pal_cursor(pal_cursor),
    .color_idx(color_idx), .pal_mode(pal_mode), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .draw_cursor(draw_cursor), .busy(busy), .done(done)
  );

  paint_ctrl_gen2 #(.X_W(5), .Y_W(5), .PAL_W(3), .PAL_SIZE(8), .WRAP(1'b0)) u_clamp (
    .clk(clk), .rst(rst), .in_init(in_init), .key_c(key_c), .key_enter(key_enter),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .wr_ack(wr_ack), .cursor_x(c_cursor_x), .cursor_y(c_cursor_y), .pal_cursor(c_pal_cursor),
    .color_idx(c_color_idx), .pal_mode(c_pal_mode), .wr_req(c_wr_req), .wr_addr(c_wr_addr),
    .wr_data(c_wr_data), .draw_cursor(c_draw_cursor), .busy(c_busy), .done(c_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // keys = {c, enter, up, down, left, right}; ack raised after ack_dly request cycles per write
  task automatic run_cmd(input logic [5:0] keys, input int ack_dly);
    int k;
    int req_cnt;
    bit seen_done;
    lat = -1; n_wr = 0; req_cyc = 0; req_cnt = 0; seen_done = 1'b0;
    @(negedge clk);
    {key_c, key_enter, key_up, key_down, key_left, key_right} = keys;
    in_init = 1'b1;
    @(posedge clk);
    #1;
    in_init = 1'b0;
    {key_c, key_enter, key_up, key_down, key_left, key_right} = '0;
    for (int i = 1; i <= 60 && !seen_done; i++) begin
      @(negedge clk);
      k = i - 1;
      if (wr_req) begin
        req_cnt++;
        req_cyc++;
        wr_ack = (req_cnt > ack_dly);
        if (wr_ack && n_wr < 4) begin
          wr_log[n_wr]   = int'(wr_addr);
          data_log[n_wr] = int'(wr_data);
          n_wr++;
        end
      end else begin
        req_cnt = 0;
        wr_ack  = 1'b0;
      end
      if (done) begin
        lat = k;
        seen_done = 1'b1;
      end
    end
    wr_ack = 1'b0;
    if (!seen_done) check("done_timeout", 0, 1);
  endtask

  initial begin
    int done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_cursor", {cursor_y, cursor_x}, 0);
    check("rst_pal", {pal_mode, pal_cursor, color_idx}, 0);

    // Reset in the middle of a held write request
    key_enter = 1'b1; in_init = 1'b1;
    @(negedge clk);
    key_enter = 1'b0; in_init = 1'b0;
    repeat (3) @(negedge clk);
    check("pend_wr_req", wr_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_wr_req", wr_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_outs", {draw_cursor, done, pal_mode, wr_addr, wr_data}, 0);
    wr_ack = 1'b1;
    repeat (2) @(negedge clk);
    wr_ack = 1'b0;
    check("late_ack_wr_req", wr_req, 0);
    check("late_ack_busy", busy, 0);

`ifndef PAINT_BRUSH2X2_EN
    // Cursor movement: wrap vs clamp at both edges
    run_cmd(6'b000010, 0);
    check("left_lat", lat, 3);
    check("left_x_wrap", cursor_x, 31);
    check("left_y_wrap", cursor_y, 0);
    check("left_x_clamp", c_cursor_x, 0);
    run_cmd(6'b000001, 0);
    check("right_x_wrap", cursor_x, 0);
    check("right_x_clamp", c_cursor_x, 1);
    run_cmd(6'b001000, 0);
    check("up_y_wrap", cursor_y, 31);
    check("up_y_clamp", c_cursor_y, 0);
    run_cmd(6'b000100, 0);
    check("down_y_wrap", cursor_y, 0);
    check("down_y_clamp", c_cursor_y, 1);
    // up beats left when both pressed
    run_cmd(6'b001010, 0);
    check("prio_up_y", cursor_y, 31);
    check("prio_up_x", cursor_x, 0);
    run_cmd(6'b000100, 0);
    repeat (3) run_cmd(6'b000001, 0);
    repeat (2) run_cmd(6'b000100, 0);
    check("pos_xy", {cursor_y, cursor_x}, {5'd2, 5'd3});

    // Palette selection
    run_cmd(6'b100000, 0);
    check("palc_lat", lat, 2);
    check("palc_mode", pal_mode, 1);
    run_cmd(6'b000010, 0);
    check("pal_left1", pal_cursor, 7);
    check("pal_lat", lat, 3);
    run_cmd(6'b000010, 0);
    check("pal_left2", pal_cursor, 6);
    run_cmd(6'b001000, 0);
    check("pal_up_noop", pal_cursor, 6);
    run_cmd(6'b000010, 0);
    check("pal_left3", pal_cursor, 5);
    check("pal_cursor_still", {cursor_y, cursor_x}, {5'd2, 5'd3});
    run_cmd(6'b010000, 0);
    check("commit_color", color_idx, 5);
    check("commit_mode", pal_mode, 0);
    check("commit_lat", lat, 3);
    check("commit_nowr", n_wr, 0);

    // Paint handshake: immediate and delayed ack
    run_cmd(6'b010000, 0);
    check("paint0_lat", lat, 3);
    check("paint0_nwr", n_wr, 1);
    check("paint0_addr", wr_log[0], 'h43);
    check("paint0_data", data_log[0], 5);
    run_cmd(6'b010000, 3);
    check("paint3_lat", lat, 6);
    check("paint3_reqcyc", req_cyc, 4);
    check("paint3_addr", wr_log[0], 'h43);

    // key_c wins over everything else
    run_cmd(6'b111000, 0);
    check("combo_mode", pal_mode, 1);
    check("combo_cursor", {cursor_y, cursor_x}, {5'd2, 5'd3});
    check("combo_nwr", n_wr, 0);
    check("combo_lat", lat, 2);
    run_cmd(6'b100000, 0);
    check("combo_exit", pal_mode, 0);

    // in_init while busy is ignored: exactly one command runs
    @(negedge clk);
    key_right = 1'b1; in_init = 1'b1;
    @(negedge clk);
    key_right = 1'b0;
    @(negedge clk);
    in_init = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("busy_ignore_done", done_cnt, 1);
    check("busy_ignore_x", cursor_x, 4);
`else
    // 2x2 brush: clipped at the far corner, full at (4,4)
    run_cmd(6'b000010, 0);
    run_cmd(6'b001000, 0);
    check("brush_corner_pos", {cursor_y, cursor_x}, 'h3FF);
    run_cmd(6'b010000, 0);
    check("brush_corner_nwr", n_wr, 1);
    check("brush_corner_addr", wr_log[0], 'h3FF);
    run_cmd(6'b000001, 0);
    run_cmd(6'b000100, 0);
    repeat (4) run_cmd(6'b000001, 0);
    repeat (4) run_cmd(6'b000100, 0);
    check("brush_pos", {cursor_y, cursor_x}, 'h84);
    run_cmd(6'b010000, 1);
    check("brush_nwr", n_wr, 4);
    check("brush_a0", wr_log[0], 'h84);
    check("brush_a1", wr_log[1], 'h85);
    check("brush_a2", wr_log[2], 'hA4);
    check("brush_a3", wr_log[3], 'hA5);
    check("brush_addr_after", wr_addr, 'h84);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
